// File: rtl/prog_mod_counter.sv
// prog_mod_counter
// ----------------
// Up/down counter whose modulus M can be changed at run time. It supports a
// synchronous parallel load, one-shot or free-running operation, a
// combinational terminal-count flag, a registered wrap pulse and a saturating
// wrap-event counter.
//
// Ports
//   i_clk        clock; all state changes on the rising edge
//   i_rst        synchronous, active-high reset
//   i_en         count enable; one step per enabled cycle
//   i_up_down    1 = count up, 0 = count down
//   i_mod        modulus M; 0 encodes M = 2^WIDTH
//   i_load       synchronous parallel load strobe (wins over i_en)
//   i_load_val   load value; clamped to M-1
//   i_oneshot    1 = stop at terminal and enter DONE instead of wrapping
//   o_Q          current count (registered)
//   o_tc         terminal count for the current direction (combinational, RUN only)
//   o_wrap       one-cycle pulse on each wrap event (registered)
//   o_done       high while the FSM is in DONE (registered state bit)
//   o_wrap_cnt   saturating count of wrap events
//
// Handshake: there is none. Every input is sampled on each rising edge.
// Priority per edge is i_rst > i_load > i_en.
module prog_mod_counter #(
    parameter int WIDTH  = 8,
    parameter int WRAP_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_up_down,
    input  logic [WIDTH-1:0]  i_mod,
    input  logic              i_load,
    input  logic [WIDTH-1:0]  i_load_val,
    input  logic              i_oneshot,
    output logic [WIDTH-1:0]  o_Q,
    output logic              o_tc,
    output logic              o_wrap,
    output logic              o_done,
    output logic [WRAP_W-1:0] o_wrap_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0]  Q_ONE   = WIDTH'(1);
    localparam logic [WIDTH:0]    EXT_ONE = (WIDTH + 1)'(1);
    localparam logic [WRAP_W-1:0] CNT_ONE = WRAP_W'(1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    q_q, q_d;
    logic                wrap_q, wrap_d;
    logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;

    // The modulus arithmetic uses one extra bit, so M = 2^WIDTH is representable.
    logic [WIDTH:0]      mod_ext;
    logic [WIDTH:0]      max_ext;
    logic [WIDTH-1:0]    max_val;
    logic                out_of_range;
    logic                at_top;
    logic                at_zero;
    logic                wrap_event;

    always_comb begin
        mod_ext      = (i_mod == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, i_mod};
        max_ext      = mod_ext - EXT_ONE;
        max_val      = max_ext[WIDTH-1:0];
        // If M has been reduced below the current count, Q can lie outside the range.
        out_of_range = {1'b0, q_q} >= mod_ext;
        at_top       = {1'b0, q_q} == max_ext;
        at_zero      = (q_q == '0);
    end

    assign o_tc = (state_q == ST_RUN) && (i_up_down ? at_top : at_zero);

    always_comb begin
        q_d        = q_q;
        state_d    = state_q;
        wrap_event = 1'b0;
        wrap_cnt_d = wrap_cnt_q;

        if (i_load) begin
            q_d     = ({1'b0, i_load_val} > max_ext) ? max_val : i_load_val;
            state_d = ST_RUN;
        end else if (i_en && (state_q == ST_RUN)) begin
            if (out_of_range) begin
                // Recovery goes to 0 in either direction, including in one-shot mode.
                wrap_event = 1'b1;
                q_d        = '0;
            end else if (i_up_down) begin
                if (at_top) begin
                    wrap_event = 1'b1;
                    q_d        = i_oneshot ? q_q : '0;
                end else begin
                    q_d = q_q + Q_ONE;
                end
            end else begin
                if (at_zero) begin
                    wrap_event = 1'b1;
                    q_d        = i_oneshot ? q_q : max_val;
                end else begin
                    q_d = q_q - Q_ONE;
                end
            end

            if (wrap_event && i_oneshot) begin
                state_d = ST_DONE;
            end
        end

        wrap_d = wrap_event;
        if (wrap_event && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_q        <= '0;
            state_q    <= ST_RUN;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            q_q        <= q_d;
            state_q    <= state_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign o_Q        = q_q;
    assign o_wrap     = wrap_q;
    assign o_done     = (state_q == ST_DONE);
    assign o_wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_prog_mod_counter.sv
// Testbench for prog_mod_counter (WIDTH=4, WRAP_W=2).
// A behavioural integer model is checked against the DUT on every falling
// edge. Directed sequences with hand-computed expectations pin the model.
module tb_prog_mod_counter;

    localparam int W  = 4;
    localparam int WW = 2;
    localparam int CNT_MAX = (1 << WW) - 1;

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          i_rst, i_en, i_up_down, i_load, i_oneshot;
    logic [W-1:0]  i_mod, i_load_val;
    logic [W-1:0]  o_Q;
    logic          o_tc, o_wrap, o_done;
    logic [WW-1:0] o_wrap_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    prog_mod_counter #(.WIDTH(W), .WRAP_W(WW)) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_en(i_en),
        .i_up_down(i_up_down),
        .i_mod(i_mod),
        .i_load(i_load),
        .i_load_val(i_load_val),
        .i_oneshot(i_oneshot),
        .o_Q(o_Q),
        .o_tc(o_tc),
        .o_wrap(o_wrap),
        .o_done(o_done),
        .o_wrap_cnt(o_wrap_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mq = 0;
    int mcnt = 0;
    bit mwrap = 0;
    bit mdone = 0;
    bit model_valid = 0;
    int model_m;
    bit model_wrapped;

    always @(posedge clk) begin
        model_m = (i_mod == 0) ? (1 << W) : int'(i_mod);
        if (i_rst) begin
            mq = 0; mwrap = 0; mdone = 0; mcnt = 0;
            model_valid = 1;
        end else if (i_load) begin
            mq = (int'(i_load_val) > model_m - 1) ? model_m - 1 : int'(i_load_val);
            mdone = 0;
            mwrap = 0;
        end else if (i_en && !mdone) begin
            if (i_up_down) model_wrapped = (mq + 1 >= model_m);
            else           model_wrapped = (mq == 0) || (mq >= model_m);
            if (!model_wrapped) begin
                mq = i_up_down ? mq + 1 : mq - 1;
            end else if (mq >= model_m) begin
                mq = 0;
                mdone = i_oneshot;
            end else if (i_oneshot) begin
                mdone = 1;  // Q stays at the terminal value
            end else begin
                mq = i_up_down ? 0 : model_m - 1;
            end
            mwrap = model_wrapped;
            if (model_wrapped && mcnt < CNT_MAX) mcnt++;
        end else begin
            mwrap = 0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (model_valid) begin
            model_m = (i_mod == 0) ? (1 << W) : int'(i_mod);
            check("model_q", o_Q, mq);
            check("model_wrap", o_wrap, mwrap);
            check("model_done", o_done, mdone);
            check("model_wrap_cnt", o_wrap_cnt, mcnt);
            check("model_tc", o_tc, !mdone && (i_up_down ? (mq == model_m - 1) : (mq == 0)));
        end
    end

    // ---------------- driver tasks ----------------
    logic [W-1:0] exp_q[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        i_load = 1'b1;
        i_load_val = v;
        cyc();
        i_load = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_up_down = 1'b1; i_mod = '0;
        i_load = 1'b0; i_load_val = '0; i_oneshot = 1'b0;
        cyc();
        cyc();
        check("rst_q", o_Q, 0);
        check("rst_wrap", o_wrap, 0);
        check("rst_done", o_done, 0);
        check("rst_cnt", o_wrap_cnt, 0);
        i_rst = 1'b0;

        // Free-running up, M=10.
        i_mod = 4'd10; i_up_down = 1'b1; i_en = 1'b1;
        exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("up10_q", o_Q, exp_q.pop_front());
            check("up10_wrap", o_wrap, (i == 9));
            if (i == 8) check("up10_tc", o_tc, 1);
        end
        check("up10_cnt", o_wrap_cnt, 1);
        i_en = 1'b0;

        // Load 3, then count down across zero.
        do_load(4'd3);
        check("load3_q", o_Q, 3);
        i_up_down = 1'b0; i_en = 1'b1;
        exp_q = '{2, 1, 0, 9, 8};
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("dn10_q", o_Q, exp_q.pop_front());
            check("dn10_wrap", o_wrap, (i == 3));
            if (i == 2) check("dn10_tc", o_tc, 1);
        end
        check("dn10_cnt", o_wrap_cnt, 2);
        i_en = 1'b0;

        // One-shot up, M=5.
        do_reset();
        i_mod = 4'd5; i_up_down = 1'b1; i_oneshot = 1'b1; i_en = 1'b1;
        exp_q = '{1, 2, 3, 4, 4, 4, 4, 4};
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("os5_q", o_Q, exp_q.pop_front());
            check("os5_done", o_done, (i >= 4));
            check("os5_wrap", o_wrap, (i == 4));
        end
        check("os5_cnt", o_wrap_cnt, 1);
        check("os5_tc_done", o_tc, 0);
        i_oneshot = 1'b0;  // clearing one-shot must not leave DONE
        cyc();
        check("os5_stay_q", o_Q, 4);
        check("os5_stay_done", o_done, 1);
        i_en = 1'b0;
        do_load(4'd2);
        check("os5_load_q", o_Q, 2);
        check("os5_load_done", o_done, 0);

        // Modulus reduced below the current count.
        do_reset();
        i_mod = 4'd12; i_up_down = 1'b1; i_en = 1'b1;
        repeat (11) cyc();
        check("m12_q", o_Q, 11);
        i_en = 1'b0; i_mod = 4'd6;
        cyc();
        check("m6_hold_q", o_Q, 11);
        check("m6_hold_wrap", o_wrap, 0);
        check("m6_hold_tc", o_tc, 0);
        i_en = 1'b1;
        cyc();
        check("m6_oor_q", o_Q, 0);
        check("m6_oor_wrap", o_wrap, 1);
        i_en = 1'b0;
        do_load(4'd9);
        check("m6_clamp_q", o_Q, 5);

        // i_mod = 0 means M = 16.
        do_reset();
        i_mod = 4'd0; i_up_down = 1'b1;
        do_load(4'd15);
        check("m16_load_q", o_Q, 15);
        check("m16_tc", o_tc, 1);
        i_en = 1'b1;
        cyc();
        check("m16_wrap_q", o_Q, 0);
        check("m16_wrap", o_wrap, 1);
        i_en = 1'b0;
        do_load(4'd15);
        i_en = 1'b1; i_load = 1'b1; i_load_val = 4'd7;
        cyc();
        check("m16_loadwins_q", o_Q, 7);
        check("m16_loadwins_wrap", o_wrap, 0);
        i_load = 1'b0; i_en = 1'b0;

        // M=1: every enabled step wraps; wrap counter saturates at 3.
        do_reset();
        i_mod = 4'd1; i_en = 1'b1;
        exp_q = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("m1_q", o_Q, 0);
            check("m1_wrap", o_wrap, 1);
            check("m1_cnt", o_wrap_cnt, exp_q.pop_front());
        end
        i_rst = 1'b1;
        cyc();
        check("m1_rst_q", o_Q, 0);
        check("m1_rst_wrap", o_wrap, 0);
        check("m1_rst_done", o_done, 0);
        check("m1_rst_cnt", o_wrap_cnt, 0);
        i_rst = 1'b0;

        // One-shot down from 0 enters DONE immediately; reset leaves it.
        i_mod = 4'd3; i_up_down = 1'b0; i_oneshot = 1'b1; i_en = 1'b1;
        cyc();
        check("osdn_q", o_Q, 0);
        check("osdn_done", o_done, 1);
        check("osdn_wrap", o_wrap, 1);
        i_rst = 1'b1;
        cyc();
        check("osdn_rst_done", o_done, 0);
        i_rst = 1'b0; i_en = 1'b0; i_oneshot = 1'b0;
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
